// File: rtl/gen_scheduler.sv
// Frame-synchronous generation scheduler for the cell array: counts display frames,
// gates the frame strobe by run state and fires a generation pulse at the speed-dependent frame.
module gen_scheduler #(
  parameter int FRAME_MAX  = 199,
  parameter int SPEED_STEP = 50,
  parameter int GEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync,
  input  logic             run_req,
  input  logic             pause_req,
  input  logic             step_req,
  input  logic             clear_req,
  input  logic             load_req,
  input  logic             speed_up,
  input  logic             speed_down,
  output logic [8:0]       vsync_edge,
  output logic             edgeDet,
  output logic [1:0]       speedCounter,
  output logic             load,
  output logic             clear,
  output logic             gen_pulse,
  output logic [GEN_W-1:0] gen_count,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    PAUSE = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    LOAD  = 3'd3,
    CLEAR = 3'd4
  } state_t;

  localparam logic [8:0] FM9 = 9'(FRAME_MAX);

  state_t     st, st_nxt;
  logic [2:0] vs_pipe;  // [0],[1] synchronizer, [2] previous synced value
  logic       rise;
  logic [8:0] target;

  assign rise   = vs_pipe[1] & ~vs_pipe[2];
  assign target = FM9 - 9'(32'(speedCounter) * SPEED_STEP);

  assign gen_pulse = edgeDet && (vsync_edge == target);
  assign load      = (st == LOAD);
  assign clear     = (st == CLEAR);
  assign state     = st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_pipe    <= '0;
      vsync_edge <= '0;
      edgeDet    <= 1'b0;
    end else begin
      vs_pipe <= {vs_pipe[1:0], vsync};
      if (rise) vsync_edge <= (vsync_edge == FM9) ? 9'd0 : vsync_edge + 9'd1;
      // Strobe qualified by the state seen in the rise cycle, not the next one.
      edgeDet <= rise && (st == RUN || st == STEP);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      speedCounter <= '0;
    end else begin
      case ({speed_up, speed_down})
        2'b10:   if (speedCounter != 2'd3) speedCounter <= speedCounter + 2'd1;
        2'b01:   if (speedCounter != 2'd0) speedCounter <= speedCounter - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           gen_count <= '0;
    else if (clear)     gen_count <= '0;
    else if (gen_pulse) gen_count <= gen_count + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= PAUSE;
    else      st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      PAUSE: begin
        if      (clear_req) st_nxt = CLEAR;
        else if (load_req)  st_nxt = LOAD;
        else if (step_req)  st_nxt = STEP;
        else if (run_req)   st_nxt = RUN;
      end
      RUN: begin
        if      (clear_req) st_nxt = CLEAR;
        else if (pause_req) st_nxt = PAUSE;
      end
      STEP: begin
        // A single evolved generation ends the step.
        if      (clear_req)              st_nxt = CLEAR;
        else if (pause_req || gen_pulse) st_nxt = PAUSE;
      end
      LOAD: begin
        if      (clear_req) st_nxt = CLEAR;
        else if (!load_req) st_nxt = PAUSE;
      end
      CLEAR:   st_nxt = PAUSE;
      default: st_nxt = PAUSE;
    endcase
  end

endmodule

// File: tb/tb_gen_scheduler.sv
// Scoreboard bench for gen_scheduler: a frame/state reference model predicts each cycle's
// outputs into a queue, and a negedge monitor pops and compares them against the DUT.
module tb_gen_scheduler;
  localparam int FM = 199, SS = 50, GW = 16;

  logic clk = 1'b0;
  logic rst, vsync, run_req, pause_req, step_req, clear_req, load_req, speed_up, speed_down;
  logic [8:0]    vsync_edge;
  logic          edgeDet, load, clear, gen_pulse;
  logic [1:0]    speedCounter;
  logic [GW-1:0] gen_count;
  logic [2:0]    state;

  always #5 clk = ~clk;

  gen_scheduler #(.FRAME_MAX(FM), .SPEED_STEP(SS), .GEN_W(GW)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .run_req(run_req), .pause_req(pause_req),
    .step_req(step_req), .clear_req(clear_req), .load_req(load_req),
    .speed_up(speed_up), .speed_down(speed_down), .vsync_edge(vsync_edge),
    .edgeDet(edgeDet), .speedCounter(speedCounter), .load(load), .clear(clear),
    .gen_pulse(gen_pulse), .gen_count(gen_count), .state(state)
  );

  typedef struct {
    int fc; int ed; int spd; int ld; int clr; int gp; int gc; int st;
  } exp_t;

  exp_t q[$];
  int n_checks = 0, n_fail = 0;
  int ed_cnt = 0, gp_cnt = 0, ld_cnt = 0, ed_in_load = 0;

  // Reference model: states 0 PAUSE, 1 RUN, 2 STEP, 3 LOAD, 4 CLEAR
  bit m_s1, m_s2, m_s3, m_ed;
  int m_fc, m_spd, m_gc, m_st;

  function automatic int tgt(int s);
    return FM - s * SS;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rise, gp;
    int nst;
    exp_t e;
    if (!rst) begin
      {m_s1, m_s2, m_s3, m_ed} = '0;
      m_fc = 0; m_spd = 0; m_gc = 0; m_st = 0;
    end else begin
      rise = m_s2 && !m_s3;
      gp   = m_ed && (m_fc == tgt(m_spd));
      case (m_st)
        0: nst = clear_req ? 4 : load_req ? 3 : step_req ? 2 : run_req ? 1 : 0;
        1: nst = clear_req ? 4 : pause_req ? 0 : 1;
        2: nst = clear_req ? 4 : (pause_req || gp) ? 0 : 2;
        3: nst = clear_req ? 4 : !load_req ? 0 : 3;
        default: nst = 0;
      endcase
      if (m_st == 4) m_gc = 0;
      else if (gp)   m_gc = (m_gc + 1) % (1 << GW);
      m_ed = rise && (m_st == 1 || m_st == 2);
      if (rise) m_fc = (m_fc == FM) ? 0 : m_fc + 1;
      if (speed_up && !speed_down && m_spd < 3) m_spd++;
      if (speed_down && !speed_up && m_spd > 0) m_spd--;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = vsync;
      m_st = nst;
    end
    e.fc = m_fc; e.ed = m_ed; e.spd = m_spd; e.ld = (m_st == 3); e.clr = (m_st == 4);
    e.gp = m_ed && (m_fc == tgt(m_spd)); e.gc = m_gc; e.st = m_st;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("vsync_edge", int'(vsync_edge), e.fc);
      chk("edgeDet", int'(edgeDet), e.ed);
      chk("speedCounter", int'(speedCounter), e.spd);
      chk("load", int'(load), e.ld);
      chk("clear", int'(clear), e.clr);
      chk("gen_pulse", int'(gen_pulse), e.gp);
      chk("gen_count", int'(gen_count), e.gc);
      chk("state", int'(state), e.st);
      if (load && edgeDet) begin
        n_fail++;
        $display("FAIL load_edgeDet_overlap at %0t", $time);
      end
      ed_cnt += int'(edgeDet);
      gp_cnt += int'(gen_pulse);
      ld_cnt += int'(load);
      if (load) ed_in_load += int'(edgeDet);
    end
  end

  // Reset must clear outputs without waiting for a clock edge.
  always @(negedge rst) begin
    if ($time > 20) begin
      #1;
      chk("async_rst_outputs",
          int'(vsync_edge) + int'(edgeDet) + int'(speedCounter) + int'(load) + int'(clear) +
          int'(gen_pulse) + int'(gen_count) + int'(state), 0);
    end
  end

  task automatic cyc();
    model_step();
    @(negedge clk);
    #1;
    {run_req, pause_req, step_req, clear_req, speed_up, speed_down} = '0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      vsync = 1'b1; cyc(); cyc();
      vsync = 1'b0; cyc(); cyc();
    end
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int ed0, gp0, gc0, ld0, guard;
    rst = 1'b0; vsync = 1'b0; load_req = 1'b0;
    {run_req, pause_req, step_req, clear_req, speed_up, speed_down} = '0;
    cyc(); cyc(); cyc();
    chk("reset_state", int'(state), 0);
    rst = 1'b1; cyc();

    // Free-running at speed 0: one generation per 200 frames.
    run_req = 1'b1; cyc();
    ed0 = ed_cnt; gp0 = gp_cnt;
    frames(200); cyc(); cyc();
    chk("run200_edgeDet", ed_cnt - ed0, 200);
    chk("run200_gen_pulse", gp_cnt - gp0, 1);
    chk("run200_gen_count", int'(gen_count), 1);
    chk("run200_wrap", int'(vsync_edge), 0);

    // Speed saturation, fastest target, then back down.
    repeat (5) begin speed_up = 1'b1; cyc(); end
    chk("speed_sat_hi", int'(speedCounter), 3);
    gp0 = gp_cnt;
    frames(60); cyc(); cyc();
    chk("speed3_gen_pulse", gp_cnt - gp0, 1);
    repeat (4) begin speed_down = 1'b1; cyc(); end
    chk("speed_sat_lo", int'(speedCounter), 0);

    // Single step from PAUSE.
    pause_req = 1'b1; cyc();
    gc0 = int'(gen_count);
    step_req = 1'b1; cyc();
    chk("step_state", int'(state), 2);
    ed0 = ed_cnt; gp0 = gp_cnt;
    frames(150); cyc(); cyc();
    chk("step_edgeDet", ed_cnt - ed0, FM - 60);
    chk("step_gen_pulse", gp_cnt - gp0, 1);
    chk("step_gen_count", int'(gen_count), gc0 + 1);
    chk("step_back_pause", int'(state), 0);

    // Pattern load for 10 cycles with frames arriving.
    ld0 = ld_cnt; ed0 = ed_in_load;
    load_req = 1'b1;
    repeat (5) begin vsync = ~vsync; cyc(); cyc(); end
    load_req = 1'b0; vsync = 1'b0; cyc(); cyc();
    chk("load_cycles", ld_cnt - ld0, 10);
    chk("load_no_edgeDet", ed_in_load - ed0, 0);
    chk("load_release", int'(state), 0);
    run_req = 1'b1; cyc();
    load_req = 1'b1; cyc(); cyc();
    load_req = 1'b0;
    chk("load_in_run_ignored", int'(state), 1);

    // Clear outranks load and step in the same cycle.
    pause_req = 1'b1; cyc();
    clear_req = 1'b1; step_req = 1'b1; load_req = 1'b1; cyc();
    load_req = 1'b0;
    chk("clear_state", int'(state), 4);
    chk("clear_pulse", int'(clear), 1);
    cyc();
    chk("clear_gen_count", int'(gen_count), 0);
    chk("clear_to_pause", int'(state), 0);

    // Reset in the middle of a run at speed 2 with 5 generations.
    repeat (2) begin speed_up = 1'b1; cyc(); end
    run_req = 1'b1; cyc();
    guard = 0;
    while (m_gc < 5 && guard < 1200) begin frames(1); guard++; end
    frames(3);
    chk("pre_reset_gen_count", int'(gen_count), 5);
    chk("pre_reset_speed", int'(speedCounter), 2);
    vsync = 1'b1; cyc();
    rst = 1'b0; vsync = 1'b0; cyc(); cyc();
    rst = 1'b1; cyc();
    ed0 = ed_cnt;
    frames(3); cyc(); cyc();
    chk("post_reset_no_edgeDet", ed_cnt - ed0, 0);
    chk("post_reset_frames", int'(vsync_edge), 3);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) vsync = ~vsync;
      run_req    = ($urandom_range(0, 15) == 0);
      pause_req  = ($urandom_range(0, 40) == 0);
      step_req   = ($urandom_range(0, 20) == 0);
      clear_req  = ($urandom_range(0, 150) == 0);
      speed_up   = ($urandom_range(0, 25) == 0);
      speed_down = ($urandom_range(0, 25) == 0);
      if ($urandom_range(0, 60) == 0) load_req = ~load_req;
      if ($urandom_range(0, 999) == 0) rst = 1'b0;
      else rst = 1'b1;
      cyc();
    end
    rst = 1'b1; load_req = 1'b0; vsync = 1'b0;
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
